// File: rtl/choice_predictor_param.sv
// Tournament chooser: a table of saturating counters, indexed by global history, that picks the
// global (MSB=1) or local (MSB=0) prediction. The lookup is registered and bypasses a same-cycle update.
module choice_predictor_param #(
  parameter int IDX_W = 12,
  parameter int CTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_index,
  output logic             choice_valid,
  output logic             choice,
  output logic [CTR_W-1:0] choice_ctr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_gp_pred,
  input  logic             upd_lp_pred,
  input  logic             upd_taken
);

  // state  | meaning
  // S_INIT | sweeping CTR_INIT into every entry, one per cycle; ready=0
  // S_RUN  | table valid; lookups and updates accepted
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [IDX_W-1:0] PTR_LAST = '1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_ptr, sweep_ptr_nxt;
  logic [CTR_W-1:0] table_mem [DEPTH];

  logic [CTR_W-1:0] upd_cur, upd_new, lookup_val;
  logic             gp_ok, lp_ok, upd_we, pred_fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_INIT;
      sweep_ptr <= '0;
    end else begin
      state     <= state_nxt;
      sweep_ptr <= sweep_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_ptr_nxt = sweep_ptr;
    ready         = (state == S_RUN);
    case (state)
      S_INIT: begin
        if (clear) begin
          sweep_ptr_nxt = '0;
        end else if (sweep_ptr == PTR_LAST) begin
          state_nxt     = S_RUN;
          sweep_ptr_nxt = '0;
        end else begin
          sweep_ptr_nxt = sweep_ptr + IDX_W'(1);
        end
      end
      S_RUN: begin
        if (clear) begin
          state_nxt     = S_INIT;
          sweep_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt     = S_INIT;
        sweep_ptr_nxt = '0;
      end
    endcase
  end

  // Only a disagreement between the two predictors moves the counter.
  always_comb begin
    upd_cur = table_mem[upd_index];
    gp_ok   = (upd_gp_pred == upd_taken);
    lp_ok   = (upd_lp_pred == upd_taken);
    upd_new = upd_cur;
    if (gp_ok && !lp_ok && upd_cur != CTR_MAX)
      upd_new = upd_cur + CTR_W'(1);
    else if (!gp_ok && lp_ok && upd_cur != '0)
      upd_new = upd_cur - CTR_W'(1);
  end

  assign upd_we    = ready && !clear && upd_valid && (gp_ok != lp_ok);
  assign pred_fire = ready && !clear && pred_valid;

  always_ff @(posedge clock) begin
    if (state == S_INIT)
      table_mem[sweep_ptr] <= CTR_INIT;
    else if (upd_we)
      table_mem[upd_index] <= upd_new;
  end

  // A same-index update in the lookup cycle must be visible to the lookup.
  assign lookup_val = (upd_we && upd_index == pred_index) ? upd_new : table_mem[pred_index];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      choice_valid <= 1'b0;
      choice       <= 1'b0;
      choice_ctr   <= '0;
    end else begin
      choice_valid <= pred_fire;
      if (pred_fire) begin
        choice_ctr <= lookup_val;
        choice     <= lookup_val[CTR_W-1];
      end
    end
  end

endmodule

// File: tb/tb_choice_predictor_param.sv
// Bench for choice_predictor_param (IDX_W=4, CTR_W=3): directed vector table, corner sequences for
// clear and reset, and a randomized phase checked against an array-of-counters reference model.
module tb_choice_predictor_param;
  localparam int IDX_W = 4;
  localparam int CTR_W = 3;
  localparam int DEPTH = 16;

  logic             clock, reset, clear, ready;
  logic             pred_valid, choice_valid, choice;
  logic [IDX_W-1:0] pred_index, upd_index;
  logic [CTR_W-1:0] choice_ctr;
  logic             upd_valid, upd_gp_pred, upd_lp_pred, upd_taken;

  choice_predictor_param #(.IDX_W(IDX_W), .CTR_W(CTR_W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready),
    .pred_valid(pred_valid), .pred_index(pred_index),
    .choice_valid(choice_valid), .choice(choice), .choice_ctr(choice_ctr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_gp_pred(upd_gp_pred),
    .upd_lp_pred(upd_lp_pred), .upd_taken(upd_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic pv; logic [3:0] pi;
    logic uv; logic [3:0] ui; logic gp; logic lp; logic tk;
    logic ev; int ec;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   model[DEPTH];
  int   hold_ctr;

  function automatic vec_t mk(logic pv, int pi, logic uv, int ui, logic gp, logic lp, logic tk,
                              logic ev, int ec);
    vec_t v;
    v.pv = pv; v.pi = 4'(pi); v.uv = uv; v.ui = 4'(ui);
    v.gp = gp; v.lp = lp; v.tk = tk; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic pv, logic [3:0] pi, logic uv, logic [3:0] ui, logic gp, logic lp, logic tk);
    pred_valid = pv; pred_index = pi;
    upd_valid = uv; upd_index = ui; upd_gp_pred = gp; upd_lp_pred = lp; upd_taken = tk;
  endtask

  // Reference rules: a counter rises when only the global predictor was right, falls when only the local one was.
  task automatic model_update(logic uv, logic [3:0] ui, logic gp, logic lp, logic tk);
    int i;
    i = int'(ui);
    if (uv) begin
      if (gp == tk && lp != tk && model[i] < 7) model[i] = model[i] + 1;
      else if (gp != tk && lp == tk && model[i] > 0) model[i] = model[i] - 1;
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = 4;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Test 2: idx 5 climbs to 7 and saturates; every update is paired with a same-index lookup.
    vecs.push_back(mk(1, 5, 1, 5, 1, 0, 1, 1, 5));
    vecs.push_back(mk(1, 5, 1, 5, 1, 0, 1, 1, 6));
    vecs.push_back(mk(1, 5, 1, 5, 1, 0, 1, 1, 7));
    vecs.push_back(mk(1, 5, 1, 5, 1, 0, 1, 1, 7));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 1, 7));
    // Test 3: idx 9 falls to 0 and saturates; agreement leaves it alone.
    vecs.push_back(mk(1, 9, 1, 9, 1, 0, 0, 1, 3));
    vecs.push_back(mk(1, 9, 1, 9, 1, 0, 0, 1, 2));
    vecs.push_back(mk(1, 9, 1, 9, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 9, 1, 9, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 9, 1, 9, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 9, 1, 9, 1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 1, 0));
    // Test 4: idx 2 back-to-back decrements with bypassed lookups.
    vecs.push_back(mk(1, 2, 1, 2, 0, 1, 1, 1, 3));
    vecs.push_back(mk(1, 2, 1, 2, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 2));
    // Different index in the same cycle, then both-wrong (no change), then idle hold.
    vecs.push_back(mk(1, 4, 1, 3, 1, 0, 1, 1, 4));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 5));
    vecs.push_back(mk(1, 3, 1, 3, 0, 0, 1, 1, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5));

    // Test 1: reset values, sweep length, all entries initialised to 4.
    tick(); tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_valid", int'(choice_valid), 0);
    chk("rst_choice", int'(choice), 0);
    chk("rst_ctr", int'(choice_ctr), 0);
    pred_valid = 1'b1;
    tick();
    chk("rst_ignore_pred", int'(choice_valid), 0);
    pred_valid = 1'b0;
    reset = 1'b1;
    wait_ready(n);
    chk("sweep_len_initial", n, 16);
    model_init();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'(i), 0, 0, 0, 0, 0);
      tick();
      chk("init_valid", int'(choice_valid), 1);
      chk("init_ctr", int'(choice_ctr), model[i]);
      chk("init_choice", int'(choice), 1);
    end

    foreach (vecs[k]) begin
      drive(vecs[k].pv, vecs[k].pi, vecs[k].uv, vecs[k].ui, vecs[k].gp, vecs[k].lp, vecs[k].tk);
      model_update(vecs[k].uv, vecs[k].ui, vecs[k].gp, vecs[k].lp, vecs[k].tk);
      tick();
      chk("vec_valid", int'(choice_valid), int'(vecs[k].ev));
      chk("vec_ctr", int'(choice_ctr), vecs[k].ec);
      chk("vec_choice", int'(choice), (vecs[k].ec >= 4) ? 1 : 0);
    end
    hold_ctr = vecs[vecs.size()-1].ec;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      logic pv, uv, gp, lp, tk;
      logic [3:0] pi, ui;
      pv = 1'($urandom); uv = 1'($urandom);
      gp = 1'($urandom); lp = 1'($urandom); tk = 1'($urandom);
      pi = 4'($urandom_range(0, 15));
      ui = ($urandom_range(0, 3) == 0) ? pi : 4'($urandom_range(0, 15));
      drive(pv, pi, uv, ui, gp, lp, tk);
      model_update(uv, ui, gp, lp, tk);
      if (pv) hold_ctr = model[int'(pi)];
      tick();
      chk("rnd_valid", int'(choice_valid), int'(pv));
      chk("rnd_ctr", int'(choice_ctr), hold_ctr);
      chk("rnd_choice", int'(choice), (hold_ctr >= 4) ? 1 : 0);
    end

    // Test 5: clear with a same-cycle update to idx 5; the update is dropped.
    clear = 1'b1;
    drive(1, 5, 1, 5, 1, 0, 1);
    tick();
    clear = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("clr_ready", int'(ready), 0);
    chk("clr_valid", int'(choice_valid), 0);
    wait_ready(n);
    chk("sweep_len_clear", n, 16);
    model_init();
    drive(1, 5, 0, 0, 0, 0, 0);
    tick();
    chk("clr_idx5_ctr", int'(choice_ctr), model[5]);
    chk("clr_idx5_choice", int'(choice), 1);

    // Test 6: async reset at sweep_ptr=7, then a full sweep again.
    drive(0, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_sweep_ready", int'(ready), 0);
    reset = 1'b0;
    #1;
    chk("arst_ready", int'(ready), 0);
    chk("arst_ctr", int'(choice_ctr), 0);
    chk("arst_choice", int'(choice), 0);
    tick();
    reset = 1'b1;
    wait_ready(n);
    chk("sweep_len_reset", n, 16);
    for (int i = 0; i < DEPTH; i += 5) begin
      drive(1, 4'(i), 0, 0, 0, 0, 0);
      tick();
      chk("post_rst_ctr", int'(choice_ctr), 4);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
